// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the data-memory access controller.
// Refill FSM states, write-buffer entry layout and byte-mask width.
package mem_pkg;

  localparam int MEM_W  = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    READ,
    FILL
  } mem_state_t;

  typedef struct packed {
    logic [MEM_W-1:0]  addr;
    logic [MEM_W-1:0]  data;
    logic [MASK_W-1:0] mask;
  } wbuf_entry_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: M-stage request, RAM port and status bundle.
// slave = controller side, master = pipeline/memory side.
interface mem_access_ctrl_if
  import mem_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int WBUF_DEPTH = 4
);

  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

  logic              ld_req;
  logic              st_req;
  logic [WIDTH-1:0]  addr;
  logic [WIDTH-1:0]  st_data;
  logic [MASK_W-1:0] st_mask;
  logic              cache_hit;
  logic [WIDTH-1:0]  ram_rdata;
  logic              ram_wready;
  logic              stall;
  logic              cache_fill;
  logic [WIDTH-1:0]  fill_data;
  logic              ram_re;
  logic              ram_we;
  logic [WIDTH-1:0]  ram_addr;
  logic [WIDTH-1:0]  ram_wdata;
  logic [MASK_W-1:0] ram_wmask;
  logic [CNT_W-1:0]  wbuf_count;
  logic [31:0]       miss_cnt;
  logic [31:0]       stall_cnt;

  modport slave (
    input  ld_req, st_req, addr, st_data,
    input  st_mask, cache_hit, ram_rdata,
    input  ram_wready,
    output stall, cache_fill, fill_data,
    output ram_re, ram_we, ram_addr,
    output ram_wdata, ram_wmask, wbuf_count,
    output miss_cnt, stall_cnt
  );

  modport master (
    output ld_req, st_req, addr, st_data,
    output st_mask, cache_hit, ram_rdata,
    output ram_wready,
    input  stall, cache_fill, fill_data,
    input  ram_re, ram_we, ram_addr,
    input  ram_wdata, ram_wmask, wbuf_count,
    input  miss_cnt, stall_cnt
  );

endinterface

// File: rtl/wbuf_fifo.sv
// wbuf_fifo: store write buffer, circular FIFO with head-entry output.
// Pointers wrap naturally because DEPTH is a power of two.
module wbuf_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  wbuf_entry_t            wr_entry,
  output wbuf_entry_t            head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wbuf_entry_t   mem_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[head_q];
  assign count   = cnt_q;

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[tail_q] <= wr_entry;
    end
  end

  // Head/tail pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load-miss refill sequencer and store write buffer.
// Optional perf counters: define MEM_ACCESS_CTRL_PERF_EN.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int RAM_LATENCY = 3,
  parameter int WBUF_DEPTH  = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WBUF_DEPTH) + 1;
  localparam int LW =
    (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_M1 =
    LW'(RAM_LATENCY - 1);

  mem_state_t       state_q;
  mem_state_t       state_d;
  logic [LW-1:0]    lat_q;
  logic [WIDTH-1:0] fill_q;
  logic [WIDTH-1:0] word_addr;
  logic             miss;
  logic             drain_ok;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             rd_first;
  logic             rd_done;
  logic             stall_w;
  wbuf_entry_t      wr_entry;
  wbuf_entry_t      head;
  logic [CW-1:0]    count;

  assign word_addr = bus.addr & ~WIDTH'(3);
  assign miss      = bus.ld_req & ~bus.cache_hit;
  assign drain_ok  = (state_q == IDLE) |
                     (state_q == DRAIN);
  assign pop       = drain_ok & ~empty &
                     bus.ram_wready;
  assign push      = (state_q == IDLE) &
                     bus.st_req & ~full;
  assign rd_first  = (state_q == READ) &
                     (lat_q == LAT_M1);
  assign rd_done   = (state_q == READ) &
                     (lat_q == '0);

  assign wr_entry.addr = MEM_W'(word_addr);
  assign wr_entry.data = MEM_W'(bus.st_data);
  assign wr_entry.mask = bus.st_mask;

  wbuf_fifo #(
    .DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: drain buffered stores before a refill read.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss)
                 state_d = empty ? READ : DRAIN;
      DRAIN:   if (empty) state_d = READ;
      READ:    if (lat_q == '0) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latency down-counter, loaded on entry to READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q <= '0;
    end else if (state_d == READ &&
                 state_q != READ) begin
      lat_q <= LAT_M1;
    end else if (state_q == READ &&
                 lat_q != '0) begin
      lat_q <= lat_q - 1'b1;
    end
  end

  // Refill word capture on the last READ cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fill_q <= '0;
    else if (rd_done) fill_q <= bus.ram_rdata;
  end

  // A held load must not see stall while reset is low.
  assign stall_w = rst_n & ((state_q != IDLE) | miss |
                   (bus.st_req & full));

  assign bus.stall      = stall_w;
  assign bus.cache_fill = (state_q == FILL);
  assign bus.fill_data  = fill_q;
  assign bus.ram_re     = rd_first;
  assign bus.ram_we     = pop;
  assign bus.ram_addr   =
    rd_first ? word_addr :
    pop      ? WIDTH'(head.addr) : '0;
  assign bus.ram_wdata  =
    pop ? WIDTH'(head.data) : '0;
  assign bus.ram_wmask  =
    pop ? head.mask : '0;
  assign bus.wbuf_count = count;

`ifdef MEM_ACCESS_CTRL_PERF_EN
  logic [31:0] miss_q;
  logic [31:0] stall_q;

  // Saturating miss and stall-cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_q  <= '0;
      stall_q <= '0;
    end else begin
      if (state_q == IDLE && state_d != IDLE &&
          miss_q != '1)
        miss_q <= miss_q + 32'd1;
      if (stall_w && stall_q != '1)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.miss_cnt  = miss_q;
  assign bus.stall_cnt = stall_q;
`else
  assign bus.miss_cnt  = '0;
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random checks of mem_access_ctrl
// against a transaction-level model (store queue + refill timer).
module tb_mem_access_ctrl;

  localparam int W = 32;
  localparam int L = 3;
  localparam int D = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.WIDTH(W), .WBUF_DEPTH(D)) bus ();

  mem_access_ctrl #(
    .WIDTH(W), .RAM_LATENCY(L), .WBUF_DEPTH(D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model
  ent_t        q[$];
  bit          m_busy = 0;
  bit          m_fill = 0;
  int          m_rd = -1;
  logic [31:0] m_ld_addr = '0;
  logic [31:0] m_fill_data = '0;
  longint      m_miss = 0;
  longint      m_stall = 0;
  bit          last_stall = 0;

  // observations
  int          cyc = 0;
  int          n_re, n_we, n_stall;
  int          first_re, last_we, fill_at;
  bit          obs_stall;
  logic [31:0] re_addr, fill_seen;
  logic [31:0] wlog[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    cyc = 0; n_re = 0; n_we = 0; n_stall = 0;
    first_re = -1; last_we = -1; fill_at = -1;
    re_addr = '0; fill_seen = '0;
    wlog.delete();
  endtask

  function automatic bit rnd_wr(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic tick(input bit ld, input bit st,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] m,
                      input bit hit, input bit wr,
                      input logic [31:0] rd);
    int n;
    bit idle, full, dok, e_we, e_re, e_stall, push;
    logic [31:0] e_addr, e_wd;
    logic [3:0] e_wm;
    ent_t e;
    bus.ld_req = ld; bus.st_req = st;
    bus.addr = a; bus.st_data = d;
    bus.st_mask = m; bus.cache_hit = hit;
    bus.ram_wready = wr; bus.ram_rdata = rd;
    n = q.size();
    full = (n == D);
    idle = !m_busy;
    dok = idle || (m_rd < 0 && !m_fill);
    e_we = dok && n > 0 && wr;
    e_re = m_busy && m_rd == 0;
    e_stall = m_busy || (ld && !hit) || (st && full);
    push = idle && st && !full;
    e_addr = e_re ? {m_ld_addr[31:2], 2'b00}
           : e_we ? q[0].a : 32'h0;
    e_wd = e_we ? q[0].d : 32'h0;
    e_wm = e_we ? q[0].m : 4'h0;
    @(negedge clk);
    chk("stall", bus.stall, e_stall);
    chk("ram_re", bus.ram_re, e_re);
    chk("ram_we", bus.ram_we, e_we);
    chk("ram_addr", bus.ram_addr, e_addr);
    chk("ram_wdata", bus.ram_wdata, e_wd);
    chk("ram_wmask", bus.ram_wmask, e_wm);
    chk("cache_fill", bus.cache_fill, m_fill);
    chk("fill_data", bus.fill_data, m_fill_data);
    chk("wbuf_count", bus.wbuf_count, n);
`ifdef MEM_ACCESS_CTRL_PERF_EN
    chk("miss_cnt", bus.miss_cnt, m_miss);
    chk("stall_cnt", bus.stall_cnt, m_stall);
`else
    chk("miss_cnt", bus.miss_cnt, 0);
    chk("stall_cnt", bus.stall_cnt, 0);
`endif
    obs_stall = bus.stall;
    if (bus.stall) n_stall++;
    if (bus.ram_re) begin
      n_re++;
      re_addr = bus.ram_addr;
      if (first_re < 0) first_re = cyc;
    end
    if (bus.ram_we) begin
      n_we++;
      last_we = cyc;
      wlog.push_back(bus.ram_wdata);
    end
    if (bus.cache_fill) begin
      fill_at = cyc;
      fill_seen = bus.fill_data;
    end
    // advance model
    last_stall = e_stall;
    if (e_we) void'(q.pop_front());
    if (push) begin
      e.a = {a[31:2], 2'b00};
      e.d = d;
      e.m = m;
      q.push_back(e);
    end
    if (e_stall && m_stall != 64'hFFFF_FFFF)
      m_stall++;
    if (idle) begin
      if (ld && !hit) begin
        m_busy = 1;
        m_ld_addr = a;
        m_rd = (n == 0) ? 0 : -1;
        m_miss++;
      end
    end else if (m_fill) begin
      m_busy = 0;
      m_fill = 0;
    end else if (m_rd < 0) begin
      if (n == 0) m_rd = 0;
    end else if (m_rd == L - 1) begin
      m_fill_data = rd;
      m_fill = 1;
      m_rd = -1;
    end else begin
      m_rd++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_load(input logic [31:0] a,
                         input bit hit,
                         input logic [31:0] rd,
                         input int pct);
    int g = 0;
    tick(1, 0, a, 0, 0, hit, rnd_wr(pct), rd);
    if (!hit) begin
      while (m_busy && g < 100) begin
        tick(1, 0, a, 0, 0, 0, rnd_wr(pct), rd);
        g++;
      end
      chk("load_bound", g < 100, 1);
      tick(1, 0, a, 0, 0, 1, rnd_wr(pct), rd);
    end
  endtask

  task automatic do_store(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0] m,
                          input int pct);
    int g = 0;
    tick(0, 1, a, d, m, 0, rnd_wr(pct), 0);
    while (last_stall && g < 50) begin
      tick(0, 1, a, d, m, 0, rnd_wr(pct), 0);
      g++;
    end
    chk("store_bound", g < 50, 1);
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_fill = 0; m_rd = -1;
    m_fill_data = '0; m_miss = 0; m_stall = 0;
    last_stall = 0;
  endtask

  logic [31:0] sd[5];

  initial begin
    bus.ld_req = 1; bus.st_req = 0;
    bus.addr = 32'h104; bus.st_data = 0;
    bus.st_mask = 0; bus.cache_hit = 0;
    bus.ram_wready = 1; bus.ram_rdata = 0;
    #2;
    chk("rst_stall", bus.stall, 0);
    chk("rst_re", bus.ram_re, 0);
    chk("rst_we", bus.ram_we, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_fill", bus.cache_fill, 0);
    chk("rst_fdata", bus.fill_data, 0);
    chk("rst_count", bus.wbuf_count, 0);
    bus.ld_req = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;

    // load hit, empty buffer
    clr_stats();
    do_load(32'h40, 1, 32'h0, 100);
    chk("hit_re", n_re, 0);
    chk("hit_stall", n_stall, 0);

    // load miss
    clr_stats();
    do_load(32'h104, 0, 32'hDEADBEEF, 100);
    chk("miss_re_pulses", n_re, 1);
    chk("miss_re_addr", re_addr, 32'h104);
    chk("miss_stall_after", n_stall - 1, L + 1);
    chk("miss_fill_cycle", fill_at, L + 1);
    chk("miss_fill_data", fill_seen, 32'hDEADBEEF);

    // store backpressure
    clr_stats();
    for (int i = 0; i < 5; i++) sd[i] = $urandom;
    for (int i = 0; i < 4; i++)
      tick(0, 1, 32'h200 + 4 * i, sd[i], 4'hF,
           0, 0, 0);
    tick(0, 1, 32'h210, sd[4], 4'h3, 0, 0, 0);
    chk("bp_stall5", obs_stall, 1);
    chk("bp_count4", bus.wbuf_count, D);
    tick(0, 1, 32'h210, sd[4], 4'h3, 0, 1, 0);
    chk("bp_stall_pop", obs_stall, 1);
    tick(0, 1, 32'h210, sd[4], 4'h3, 0, 1, 0);
    chk("bp_accept", obs_stall, 0);
    for (int i = 0; i < 4; i++)
      tick(0, 0, 0, 0, 0, 0, 1, 0);
    chk("bp_drained", wlog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < wlog.size())
        chk($sformatf("bp_order%0d", i),
            wlog[i], sd[i]);

    // miss behind two buffered stores
    clr_stats();
    tick(0, 1, 32'h380, $urandom, 4'hF, 0, 0, 0);
    tick(0, 1, 32'h384, $urandom, 4'hC, 0, 0, 0);
    clr_stats();
    do_load(32'h300, 0, $urandom, 100);
    chk("mb_we_cnt", n_we, 2);
    chk("mb_we_first", last_we < first_re, 1);
    chk("mb_stall_after", n_stall - 1, 2 + L + 1);

    // reset during READ
    clr_stats();
    tick(1, 0, 32'h500, 0, 0, 0, 1, 32'h1234);
    tick(1, 0, 32'h500, 0, 0, 0, 1, 32'h1234);
    rst_n = 0;
    #1;
    chk("mr_stall", bus.stall, 0);
    chk("mr_re", bus.ram_re, 0);
    chk("mr_we", bus.ram_we, 0);
    chk("mr_addr", bus.ram_addr, 0);
    chk("mr_wdata", bus.ram_wdata, 0);
    chk("mr_wmask", bus.ram_wmask, 0);
    chk("mr_fill", bus.cache_fill, 0);
    chk("mr_fdata", bus.fill_data, 0);
    chk("mr_count", bus.wbuf_count, 0);
    chk("mr_miss", bus.miss_cnt, 0);
    chk("mr_scnt", bus.stall_cnt, 0);
    model_reset();
    bus.ld_req = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    clr_stats();
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    do_load(32'h500, 1, 0, 100);
    chk("mr_idle_stall", n_stall, 0);
    chk("mr_idle_re", n_re, 0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(9);
      if (r < 4)
        do_load($urandom, $urandom_range(1), $urandom,
                60);
      else if (r < 7)
        do_store($urandom, $urandom,
                 4'($urandom_range(15)), 40);
      else
        tick(0, 0, $urandom, 0, 0,
             $urandom_range(1), rnd_wr(60), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
